// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, scan FSM states,
// and the hex glyph encodings (bit6=a .. bit0=g, active-high).
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [6:0] HEX_0 = 7'h7E;
    localparam logic [6:0] HEX_1 = 7'h30;
    localparam logic [6:0] HEX_2 = 7'h6D;
    localparam logic [6:0] HEX_3 = 7'h79;
    localparam logic [6:0] HEX_4 = 7'h33;
    localparam logic [6:0] HEX_5 = 7'h5B;
    localparam logic [6:0] HEX_6 = 7'h5F;
    localparam logic [6:0] HEX_7 = 7'h70;
    localparam logic [6:0] HEX_8 = 7'h7F;
    localparam logic [6:0] HEX_9 = 7'h7B;
    localparam logic [6:0] HEX_A = 7'h77;
    localparam logic [6:0] HEX_B = 7'h1F;
    localparam logic [6:0] HEX_C = 7'h4E;
    localparam logic [6:0] HEX_D = 7'h3D;
    localparam logic [6:0] HEX_E = 7'h4F;
    localparam logic [6:0] HEX_F = 7'h47;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to 7-segment glyph decoder (a..g, active-high).
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Glyph lookup; lower-case b and d keep them distinct from 8 and 0.
    always_comb begin
        seg_o = 7'h00;
        case (nib_i)
            4'h0: seg_o = HEX_0;
            4'h1: seg_o = HEX_1;
            4'h2: seg_o = HEX_2;
            4'h3: seg_o = HEX_3;
            4'h4: seg_o = HEX_4;
            4'h5: seg_o = HEX_5;
            4'h6: seg_o = HEX_6;
            4'h7: seg_o = HEX_7;
            4'h8: seg_o = HEX_8;
            4'h9: seg_o = HEX_9;
            4'hA: seg_o = HEX_A;
            4'hB: seg_o = HEX_B;
            4'hC: seg_o = HEX_C;
            4'hD: seg_o = HEX_D;
            4'hE: seg_o = HEX_E;
            4'hF: seg_o = HEX_F;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller. A load strobe captures the value
// into a shadow register; the display register copies the shadow only when
// the scan re-enters digit 0, so a frame never shows a mix of two values.
// Each digit gets BLANK_CYCLES of dead time, then DWELL_CYCLES lit.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int DWELL_CYCLES   = 4096,
    parameter int BLANK_CYCLES   = 64,
    parameter int EN_ACTIVE_HIGH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*DIGITS-1:0]       value,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [DIGITS-1:0]         en,
    output logic [$clog2(DIGITS)-1:0] digit_idx,
    output logic                      frame_done
);

    localparam int IW   = $clog2(DIGITS);
    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    // Enable pattern with every digit off, in board polarity.
    localparam logic [DIGITS-1:0] EN_OFF     = {DIGITS{(EN_ACTIVE_HIGH == 0)}};
    localparam logic [DIGITS-1:0] EN_ONE     = DIGITS'(1);

    scan_state_e         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_val_q;
    logic [DIGITS-1:0]   shadow_dp_q;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                fd_q, fd_d;

    logic [3:0]          cur_nib;
    logic [6:0]          cur_glyph;

    assign cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];

    hex7seg u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_glyph)
    );

    // Shadow capture: last load before the frame boundary wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
        end else if (load) begin
            shadow_val_q <= value;
            shadow_dp_q  <= dp_in;
        end
    end

    // Next-state, display swap and next output pattern. Outputs are computed
    // from the next state so seg/en switch on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        fd_d       = 1'b0;
        seg_d      = 7'h00;
        dp_d       = 1'b0;
        en_d       = EN_OFF;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        // Frame boundary: old shadow becomes visible; a load
                        // on this same edge lands in the shadow for next time.
                        idx_d      = '0;
                        fd_d       = 1'b1;
                        disp_val_d = shadow_val_q;
                        disp_dp_d  = shadow_dp_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
        // The index only moves on SHOW->BLANK, so idx_q is the lit digit.
        if (state_d == SHOW) begin
            seg_d = cur_glyph;
            dp_d  = disp_dp_q[idx_q];
            en_d  = EN_OFF ^ (EN_ONE << idx_q);
        end
    end

    // Scan state, counters, display buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= 7'h00;
            dp_q       <= 1'b0;
            en_q       <= EN_OFF;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            en_q       <= en_d;
            fd_q       <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign en         = en_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule
